// File: rtl/apb3_arb_pkg.sv
// ----------------------------------------------------------------------------
// apb3_arb_pkg
// Shared definitions for the APB3 request arbiter:
//   - arb_state_e : APB3 sequencing states (IDLE / SETUP / ACCESS)
//   - cnt_width() : width of a counter able to hold 0..max_count, never below 1
// ----------------------------------------------------------------------------
package apb3_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } arb_state_e;

    function automatic int cnt_width(input int max_count);
        int w;
        w = $clog2(max_count + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Searches the request vector starting one
// position after the previous winner, wrapping modulo N.
// Ports:
//   req_i      [N-1:0]      candidate requests
//   last_gnt_i [IDX_W-1:0]  index of the previous winner
//   gnt_o      [N-1:0]      one-hot winner (all zero when nothing requests)
//   gnt_idx_o  [IDX_W-1:0]  binary index of the winner
//   valid_o                 a winner exists
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_gnt_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             valid_o
);

    always_comb begin
        int idx;
        gnt_o     = '0;
        gnt_idx_o = '0;
        valid_o   = 1'b0;
        idx       = 0;
        // Offset k=1 means the previous winner is visited last.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_gnt_i) + k) % N;
            if (!valid_o && req_i[idx]) begin
                valid_o    = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/apb3_req_arbiter.sv
// ----------------------------------------------------------------------------
// apb3_req_arbiter
// Round-robin scheduler of NUM_REQ command requesters onto one APB3 master
// port. One transfer at a time: IDLE -> SETUP -> ACCESS -> IDLE. A stuck
// ACCESS phase is aborted with an error after TIMEOUT_CYCLES cycles (0 = never).
// Ports:
//   HCLK, HRESETN                 clock, asynchronous active-low reset
//   req_i/req_write_i             per-requester request level and direction
//   req_addr_i/req_wdata_i        flattened per-requester commands
//   ack_o                         one-cycle one-hot completion pulse
//   rdata_o, err_o, timeout_o     completion results (zero outside completion)
//   PSEL..PWDATA                  APB3 master outputs (registered)
//   PRDATA, PREADY, PSLVERR       APB3 slave responses
// ----------------------------------------------------------------------------
module apb3_req_arbiter
    import apb3_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             HCLK,
    input  logic                             HRESETN,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ-1:0]               req_write_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata_i,
    output logic [NUM_REQ-1:0]               ack_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             err_o,
    output logic                             timeout_o,
    output logic                             PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    input  logic [DATA_WIDTH-1:0]            PRDATA,
    input  logic                             PREADY,
    input  logic                             PSLVERR
);

    localparam int                IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int                CNT_W      = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [IDX_W-1:0]  LAST_RST   = IDX_W'(NUM_REQ - 1);

    arb_state_e              state_q;
    logic [IDX_W-1:0]        last_gnt_q;
    logic [NUM_REQ-1:0]      gnt_oh_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    psel_q;
    logic                    penable_q;
    logic                    pwrite_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [NUM_REQ-1:0]      ack_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic                    timeout_q;

    // Split the flattened command buses into per-requester arrays.
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[gi] = req_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // A requester being acked this cycle still shows req_i high (it may be
    // presenting its next command) but must not be re-granted immediately.
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant_oh;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;

    assign eligible = req_i & ~ack_q;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i      (eligible),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (grant_oh),
        .gnt_idx_o  (grant_idx),
        .valid_o    (grant_valid)
    );

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= LAST_RST;
            gnt_oh_q   <= '0;
            cnt_q      <= '0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            // Completion outputs are pulses; only the completing branch sets them.
            ack_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        pwrite_q   <= req_write_i[grant_idx];
                        paddr_q    <= addr_arr[grant_idx];
                        pwdata_q   <= wdata_arr[grant_idx];
                        psel_q     <= 1'b1;
                        last_gnt_q <= grant_idx;
                        gnt_oh_q   <= grant_oh;
                        cnt_q      <= '0;
                        state_q    <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (PREADY) begin
                        // A ready response wins even on the would-be timeout cycle.
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        state_q   <= ST_IDLE;
                        ack_q     <= gnt_oh_q;
                        rdata_q   <= pwrite_q ? '0 : PRDATA;
                        err_q     <= PSLVERR;
                    end else begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        // cnt_q counts earlier waited cycles, so this is the
                        // TIMEOUT_CYCLES-th ACCESS cycle.
                        if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                            psel_q    <= 1'b0;
                            penable_q <= 1'b0;
                            state_q   <= ST_IDLE;
                            ack_q     <= gnt_oh_q;
                            err_q     <= 1'b1;
                            timeout_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack_o     = ack_q;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;
    assign timeout_o = timeout_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb3_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_apb3_req_arbiter
// Main instance: 3 requesters, 4-cycle timeout. Second instance: 2 requesters,
// timeout disabled. Inputs are driven and outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_apb3_req_arbiter;

    localparam int NR = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic HCLK = 1'b0;
    logic HRESETN = 1'b0;
    always #5 HCLK = ~HCLK;

    // main instance signals
    logic [NR-1:0]    req_i, req_write_i, ack_o;
    logic [NR*AW-1:0] req_addr_i;
    logic [NR*DW-1:0] req_wdata_i;
    logic [DW-1:0]    rdata_o, PWDATA, PRDATA;
    logic [AW-1:0]    PADDR;
    logic             err_o, timeout_o, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

    // no-timeout instance signals
    logic [1:0]       nt_req, nt_write, nt_ack;
    logic [2*AW-1:0]  nt_addr;
    logic [2*DW-1:0]  nt_wdata;
    logic [DW-1:0]    nt_rdata, nt_pwdata, nt_prdata;
    logic [AW-1:0]    nt_paddr;
    logic             nt_err, nt_timeout, nt_psel, nt_penable, nt_pwrite, nt_pready, nt_pslverr;

    apb3_req_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .HCLK(HCLK), .HRESETN(HRESETN),
        .req_i(req_i), .req_write_i(req_write_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o), .timeout_o(timeout_o),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb3_req_arbiter #(
        .NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)
    ) u_dut_nt (
        .HCLK(HCLK), .HRESETN(HRESETN),
        .req_i(nt_req), .req_write_i(nt_write), .req_addr_i(nt_addr), .req_wdata_i(nt_wdata),
        .ack_o(nt_ack), .rdata_o(nt_rdata), .err_o(nt_err), .timeout_o(nt_timeout),
        .PSEL(nt_psel), .PENABLE(nt_penable), .PWRITE(nt_pwrite), .PADDR(nt_paddr), .PWDATA(nt_pwdata),
        .PRDATA(nt_prdata), .PREADY(nt_pready), .PSLVERR(nt_pslverr)
    );

    // requester-side model
    logic [NR-1:0] req_drv;
    logic          cmd_write [NR];
    logic [AW-1:0] cmd_addr  [NR];
    logic [DW-1:0] cmd_wdata [NR];
    int            tb_last;     // expected previous round-robin winner
    int            checks = 0;
    int            passes = 0;

    task automatic drive_cmds();
        for (int n = 0; n < NR; n++) begin
            req_write_i[n]          = cmd_write[n];
            req_addr_i[n*AW +: AW]  = cmd_addr[n];
            req_wdata_i[n*DW +: DW] = cmd_wdata[n];
        end
        req_i = req_drv;
    endtask

    task automatic new_cmd(input int n);
        cmd_write[n] = 1'($urandom_range(0, 1));
        cmd_addr[n]  = $urandom & 32'hFFFF_FFFC;
        cmd_wdata[n] = $urandom;
    endtask

    // Round-robin rule: first pending index after the previous winner.
    function automatic int rr_pick(input logic [NR-1:0] pend, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (pend[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic test_reset();
        @(negedge HCLK);
        @(negedge HCLK);
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PWRITE !== 1'b0 || PADDR !== '0 || PWDATA !== '0)
            $display("FAIL reset_apb psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h, required all 0",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA);
        else passes++;
        checks++;
        if (ack_o !== '0 || rdata_o !== '0 || err_o !== 1'b0 || timeout_o !== 1'b0)
            $display("FAIL reset_resp ack=%b rdata=%h err=%b timeout=%b, required all 0",
                     ack_o, rdata_o, err_o, timeout_o);
        else passes++;
        HRESETN = 1'b1;
        @(negedge HCLK);
        checks++;
        if (PSEL !== 1'b0 || ack_o !== '0)
            $display("FAIL reset_idle psel=%b ack=%b, required 0 000", PSEL, ack_o);
        else passes++;
        tb_last = NR - 1;
    endtask

    task automatic test_single_read();
        cmd_write[0] = 1'b0; cmd_addr[0] = 32'h10; cmd_wdata[0] = '0;
        req_drv = 3'b001; PRDATA = 32'hCAFE_0001; PREADY = 1'b1; PSLVERR = 1'b0;
        drive_cmds();
        @(negedge HCLK);
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 32'h10 || PWRITE !== 1'b0)
            $display("FAIL single_setup psel=%b penable=%b paddr=%h pwrite=%b, required 1 0 00000010 0",
                     PSEL, PENABLE, PADDR, PWRITE);
        else passes++;
        @(negedge HCLK);
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b1 || ack_o !== '0)
            $display("FAIL single_access psel=%b penable=%b ack=%b, required 1 1 000", PSEL, PENABLE, ack_o);
        else passes++;
        @(negedge HCLK);
        checks++;
        if (ack_o !== 3'b001 || rdata_o !== 32'hCAFE_0001 || err_o !== 1'b0 || timeout_o !== 1'b0 || PSEL !== 1'b0)
            $display("FAIL single_ack ack=%b rdata=%h err=%b timeout=%b psel=%b, required 001 cafe0001 0 0 0",
                     ack_o, rdata_o, err_o, timeout_o, PSEL);
        else passes++;
        req_drv = '0; drive_cmds();
        @(negedge HCLK);
        checks++;
        if (ack_o !== '0 || rdata_o !== '0 || PSEL !== 1'b0 || PADDR !== 32'h10)
            $display("FAIL single_after ack=%b rdata=%h psel=%b paddr=%h, required 000 0 0 00000010",
                     ack_o, rdata_o, PSEL, PADDR);
        else passes++;
        tb_last = 0;
    endtask

    task automatic test_wait_slverr();
        cmd_write[1] = 1'b1; cmd_addr[1] = 32'h0000_0A40; cmd_wdata[1] = 32'h1234_5678;
        req_drv = 3'b010; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hDEAD_BEEF;
        drive_cmds();
        @(negedge HCLK);
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 32'h0000_0A40 || PWDATA !== 32'h1234_5678 || PWRITE !== 1'b1)
            $display("FAIL wait_setup psel=%b penable=%b paddr=%h pwdata=%h pwrite=%b, required 1 0 00000a40 12345678 1",
                     PSEL, PENABLE, PADDR, PWDATA, PWRITE);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            checks++;
            if (PSEL !== 1'b1 || PENABLE !== 1'b1 || ack_o !== '0)
                $display("FAIL wait_access%0d psel=%b penable=%b ack=%b, required 1 1 000", i, PSEL, PENABLE, ack_o);
            else passes++;
            if (i == 3) begin PREADY = 1'b1; PSLVERR = 1'b1; end
        end
        @(negedge HCLK);
        checks++;
        if (ack_o !== 3'b010 || err_o !== 1'b1 || timeout_o !== 1'b0 || rdata_o !== '0 || PSEL !== 1'b0)
            $display("FAIL wait_ack ack=%b err=%b timeout=%b rdata=%h psel=%b, required 010 1 0 0 0",
                     ack_o, err_o, timeout_o, rdata_o, PSEL);
        else passes++;
        req_drv = '0; drive_cmds(); PREADY = 1'b0; PSLVERR = 1'b0;
        tb_last = 1;
    endtask

    task automatic test_timeout();
        cmd_write[2] = 1'b0; cmd_addr[2] = 32'h0000_0300; cmd_wdata[2] = '0;
        req_drv = 3'b100; PREADY = 1'b0; PRDATA = 32'h5555_AAAA;
        drive_cmds();
        @(negedge HCLK);
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 32'h0000_0300)
            $display("FAIL to_setup psel=%b penable=%b paddr=%h, required 1 0 00000300", PSEL, PENABLE, PADDR);
        else passes++;
        for (int i = 0; i < TO; i++) begin
            @(negedge HCLK);
            checks++;
            if (PSEL !== 1'b1 || PENABLE !== 1'b1 || ack_o !== '0 || timeout_o !== 1'b0)
                $display("FAIL to_access%0d psel=%b penable=%b ack=%b timeout=%b, required 1 1 000 0",
                         i, PSEL, PENABLE, ack_o, timeout_o);
            else passes++;
        end
        @(negedge HCLK);
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || ack_o !== 3'b100 || err_o !== 1'b1 || timeout_o !== 1'b1 || rdata_o !== '0)
            $display("FAIL to_abort psel=%b penable=%b ack=%b err=%b timeout=%b rdata=%h, required 0 0 100 1 1 0",
                     PSEL, PENABLE, ack_o, err_o, timeout_o, rdata_o);
        else passes++;
        req_drv = '0; drive_cmds();
        @(negedge HCLK);
        checks++;
        if (ack_o !== '0 || timeout_o !== 1'b0 || err_o !== 1'b0 || PSEL !== 1'b0)
            $display("FAIL to_after ack=%b timeout=%b err=%b psel=%b, required 000 0 0 0", ack_o, timeout_o, err_o, PSEL);
        else passes++;
        tb_last = 2;
    endtask

    task automatic test_no_timeout();
        bit bad;
        nt_addr[AW-1:0] = 32'h0000_0044; nt_req = 2'b01; nt_pready = 1'b0; nt_prdata = 32'h0BAD_0BAD;
        @(negedge HCLK);
        @(negedge HCLK);
        bad = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge HCLK);
            if (!bad && (nt_psel !== 1'b1 || nt_penable !== 1'b1 || nt_ack !== 2'b00 || nt_timeout !== 1'b0)) begin
                bad = 1'b1;
                $display("FAIL nt_hold cycle=%0d psel=%b penable=%b ack=%b timeout=%b, required 1 1 00 0",
                         i, nt_psel, nt_penable, nt_ack, nt_timeout);
            end
        end
        checks++;
        if (!bad) passes++;
        nt_pready = 1'b1; nt_prdata = 32'h1234_5678;
        @(negedge HCLK);
        checks++;
        if (nt_ack !== 2'b01 || nt_rdata !== 32'h1234_5678 || nt_err !== 1'b0 || nt_timeout !== 1'b0)
            $display("FAIL nt_ack ack=%b rdata=%h err=%b timeout=%b, required 01 12345678 0 0",
                     nt_ack, nt_rdata, nt_err, nt_timeout);
        else passes++;
        nt_req = 2'b00; nt_pready = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        cmd_write[1] = 1'b0; cmd_addr[1] = 32'h0000_0110; cmd_wdata[1] = '0;
        cmd_write[0] = 1'b1; cmd_addr[0] = 32'h0000_0220; cmd_wdata[0] = 32'hA5A5_0000;
        req_drv = 3'b010; PREADY = 1'b0; drive_cmds();
        @(negedge HCLK);                          // SETUP
        @(negedge HCLK);                          // ACCESS
        req_drv = 3'b011; drive_cmds();
        @(negedge HCLK);                          // ACCESS
        #2 HRESETN = 1'b0;
        #1;
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || ack_o !== '0)
            $display("FAIL rst_mid psel=%b penable=%b ack=%b, required 0 0 000", PSEL, PENABLE, ack_o);
        else passes++;
        @(negedge HCLK);
        @(negedge HCLK);
        checks++;
        if (PSEL !== 1'b0 || ack_o !== '0)
            $display("FAIL rst_hold psel=%b ack=%b, required 0 000", PSEL, ack_o);
        else passes++;
        HRESETN = 1'b1;
        PREADY = 1'b1; PSLVERR = 1'b0;
        @(negedge HCLK);
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 32'h0000_0220 || PWRITE !== 1'b1)
            $display("FAIL rst_first psel=%b penable=%b paddr=%h pwrite=%b, required 1 0 00000220 1",
                     PSEL, PENABLE, PADDR, PWRITE);
        else passes++;
        @(negedge HCLK);
        @(negedge HCLK);
        checks++;
        if (ack_o !== 3'b001 || err_o !== 1'b0)
            $display("FAIL rst_ack0 ack=%b err=%b, required 001 0", ack_o, err_o);
        else passes++;
        req_drv = 3'b010; drive_cmds();
        @(negedge HCLK);
        checks++;
        if (PSEL !== 1'b1 || PADDR !== 32'h0000_0110)
            $display("FAIL rst_second psel=%b paddr=%h, required 1 00000110", PSEL, PADDR);
        else passes++;
        @(negedge HCLK);
        @(negedge HCLK);
        checks++;
        if (ack_o !== 3'b010)
            $display("FAIL rst_ack1 ack=%b, required 010", ack_o);
        else passes++;
        req_drv = '0; drive_cmds(); PREADY = 1'b0;
        tb_last = 1;
    endtask

    // Generic traffic engine: requesters hold/issue commands, the bench acts
    // as the APB slave, and every cycle is compared with the protocol model.
    task automatic run_traffic(input int ncyc, input logic [NR-1:0] hold, input bit rnd,
                               input bit zero_wait, output int nacks, output int first_owner);
        int phase, owner, waits, cyc;
        bit done_exp, draining, rdy;
        logic [DW-1:0] rd_sent;
        logic          err_sent;
        logic [NR-1:0] exp_ack, elig;
        phase = 0; owner = 0; waits = 0; cyc = 0; done_exp = 0; draining = 0;
        nacks = 0; first_owner = -1; rd_sent = '0; err_sent = 1'b0;
        req_drv = '0; drive_cmds(); PREADY = 1'b0;
        forever begin
            @(negedge HCLK);
            cyc++;
            checks++;
            if (PSEL !== (phase != 0) || PENABLE !== (phase == 2))
                $display("FAIL traffic_phase cyc=%0d psel=%b penable=%b, required phase %0d", cyc, PSEL, PENABLE, phase);
            else passes++;
            if (phase == 1) begin
                checks++;
                if (PADDR !== cmd_addr[owner] || PWRITE !== cmd_write[owner] || PWDATA !== cmd_wdata[owner])
                    $display("FAIL traffic_cmd cyc=%0d owner=%0d paddr=%h pwrite=%b pwdata=%h, required %h %b %h",
                             cyc, owner, PADDR, PWRITE, PWDATA, cmd_addr[owner], cmd_write[owner], cmd_wdata[owner]);
                else passes++;
            end
            exp_ack = done_exp ? (NR'(1) << owner) : '0;
            checks++;
            if (ack_o !== exp_ack || rdata_o !== (done_exp ? rd_sent : '0) ||
                err_o !== (done_exp ? err_sent : 1'b0) || timeout_o !== 1'b0)
                $display("FAIL traffic_resp cyc=%0d ack=%b rdata=%h err=%b timeout=%b, required %b %h %b 0",
                         cyc, ack_o, rdata_o, err_o, timeout_o, exp_ack,
                         done_exp ? rd_sent : '0, done_exp ? err_sent : 1'b0);
            else passes++;
            if (done_exp && cyc <= ncyc) nacks++;
            if (cyc >= ncyc) draining = 1;

            for (int n = 0; n < NR; n++) begin
                if (done_exp && owner == n) begin
                    if (!draining && (hold[n] || (rnd && $urandom_range(0, 1) == 1))) new_cmd(n);
                    else req_drv[n] = 1'b0;
                end else if (!req_drv[n] && !draining && (hold[n] || (rnd && $urandom_range(0, 2) == 0))) begin
                    new_cmd(n);
                    req_drv[n] = 1'b1;
                end
            end
            drive_cmds();

            rdy = 0;
            PRDATA = $urandom;
            PSLVERR = 1'($urandom_range(0, 1));
            if (phase == 2) begin
                if (waits == 0) rdy = 1;
                else waits--;
            end
            PREADY = rdy;
            if (rdy) begin
                rd_sent  = cmd_write[owner] ? '0 : PRDATA;
                err_sent = PSLVERR;
            end

            elig = req_drv & ~exp_ack;
            done_exp = rdy;
            case (phase)
                0: if (elig != 0) begin
                    owner = rr_pick(elig, tb_last);
                    tb_last = owner;
                    if (first_owner < 0) first_owner = owner;
                    waits = zero_wait ? 0 : $urandom_range(0, TO - 1);
                    phase = 1;
                end
                1: phase = 2;
                default: if (rdy) phase = 0;
            endcase
            if (draining && phase == 0 && req_drv == '0 && !done_exp) break;
            if (cyc > ncyc + 80) begin
                checks++;
                $display("FAIL traffic_drain cyc=%0d phase=%0d req=%b, required idle within bound", cyc, phase, req_drv);
                break;
            end
        end
        PREADY = 1'b0;
    endtask

    task automatic test_round_robin();
        int nacks, first;
        run_traffic(13, 3'b011, 1'b0, 1'b1, nacks, first);
        checks++;
        if (nacks != 4 || first != 0)
            $display("FAIL rr_count acks=%0d first=%0d, required 4 0", nacks, first);
        else passes++;
    endtask

    task automatic test_random();
        int nacks, first;
        run_traffic(500, 3'b000, 1'b1, 1'b0, nacks, first);
        checks++;
        if (nacks < 30)
            $display("FAIL random_count acks=%0d, required >= 30", nacks);
        else passes++;
    endtask

    initial begin
        req_drv = '0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
        for (int n = 0; n < NR; n++) begin
            cmd_write[n] = 1'b0; cmd_addr[n] = '0; cmd_wdata[n] = '0;
        end
        drive_cmds();
        nt_req = '0; nt_write = '0; nt_addr = '0; nt_wdata = '0;
        nt_prdata = '0; nt_pready = 1'b0; nt_pslverr = 1'b0;
        tb_last = NR - 1;

        test_reset();
        test_single_read();
        test_wait_slverr();
        test_timeout();
        test_no_timeout();
        test_reset_mid_access();
        test_round_robin();
        test_random();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
